multicycle_control_unit: RTL and testbench

- Multi-cycle CPU control FSM. Decodes the 6-bit opcode, sequences IF/ID/EXE/MEM/WB and drives every datapath enable.
- Issues ALUOp and ifNeedOf to the ALU and consumes its zero/sign/overflow flags for branch resolution and overflow writeback suppression.

---
 rtl/multicycle_control_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: decodes opcode, sequences IF/ID/EXE/MEM/WB, drives datapath enables.
// Latency: 2 (jumps), 3 (branch), 4 (ALU ops, sw) or 5 (lw) cycles per instruction; outputs combinational.
// No backpressure: halt parks the FSM in ID until RST. Optional CU_OVF_STICKY_EN adds ovf_sticky output.
module multicycle_control_unit #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    input  logic       overflow,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       ifNeedOf,
`ifdef CU_OVF_STICKY_EN
    output logic       ovf_sticky,
`endif
    output logic [4:0] link_reg
);

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b110;
    localparam logic [2:0] S_WB  = 3'b111;
    localparam logic [2:0] S_BR  = 3'b101;
    localparam logic [2:0] S_MA  = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WBL = 3'b100;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XOR   = 6'b010100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100101;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic       is_alu;
    logic       is_branch;
    logic       is_mem;
    logic       is_jump;
    logic       is_halt;
    logic       br_taken;
    logic       ovf_q;
    logic [2:0] next_state;

    assign link_reg = RA_REG;

    // Classify the opcode into the instruction groups that steer sequencing
    always_comb begin
        is_alu    = 1'b0;
        is_branch = 1'b0;
        is_mem    = 1'b0;
        is_jump   = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL,
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: is_alu    = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ:            is_branch = 1'b1;
            OP_SW, OP_LW:                       is_mem    = 1'b1;
            OP_J, OP_JR, OP_JAL:                is_jump   = 1'b1;
            OP_HALT:                            is_halt   = 1'b1;
            default: ;
        endcase
    end

    // Branch resolution from ALU flags; bltz compares rs against $0 so sign alone decides
    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BEQ:  br_taken = zero;
            OP_BNE:  br_taken = ~zero;
            OP_BLTZ: br_taken = sign;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state sequencing; undefined opcodes fall back to IF and act as a nop
    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF:  next_state = S_ID;
            S_ID: begin
                if (is_halt)        next_state = S_ID;
                else if (is_branch) next_state = S_BR;
                else if (is_mem)    next_state = S_MA;
                else if (is_alu)    next_state = S_EXE;
                else                next_state = S_IF;
            end
            S_EXE: next_state = S_WB;
            S_MA:  next_state = S_MEM;
            S_MEM: next_state = (opcode == OP_LW) ? S_WBL : S_IF;
            default: next_state = S_IF;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IF;
        else     state <= next_state;
    end

    // Overflow capture: latched when leaving EXE, dropped once WB has used it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                 ovf_q <= 1'b0;
        else if (state == S_EXE) ovf_q <= overflow & ifNeedOf;
        else if (state == S_WB)  ovf_q <= 1'b0;
    end

`ifdef CU_OVF_STICKY_EN
    // Sticky overflow record, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                         ovf_sticky <= 1'b0;
        else if (state == S_EXE && overflow && ifNeedOf) ovf_sticky <= 1'b1;
    end
`endif

    // Datapath controls: operand/ALU fields follow the opcode in every state, strobes follow the state
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b01;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        ifNeedOf  = 1'b0;

        // Reset forces the idle decode regardless of whatever sits on the opcode lines
        if (!RST) begin
            case (opcode)
                OP_ADD:   begin ALUOp = 3'b000; ifNeedOf = 1'b1; RegDst = 2'b10; end
                OP_SUB:   begin ALUOp = 3'b001; ifNeedOf = 1'b1; RegDst = 2'b10; end
                OP_AND:   begin ALUOp = 3'b100; RegDst = 2'b10; end
                OP_OR:    begin ALUOp = 3'b011; RegDst = 2'b10; end
                OP_XOR:   begin ALUOp = 3'b111; RegDst = 2'b10; end
                OP_SLT:   begin ALUOp = 3'b110; RegDst = 2'b10; end
                OP_SLL:   begin ALUOp = 3'b010; ALUSrcA = 1'b1; RegDst = 2'b10; end
                OP_ADDIU: begin ALUOp = 3'b101; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                OP_ANDI:  begin ALUOp = 3'b100; ALUSrcB = 1'b1; end
                OP_ORI:   begin ALUOp = 3'b011; ALUSrcB = 1'b1; end
                OP_SLTI:  begin ALUOp = 3'b110; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                OP_SW, OP_LW: begin ALUOp = 3'b101; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                OP_BEQ, OP_BNE, OP_BLTZ: begin ALUOp = 3'b001; ExtSel = 1'b1; end
                OP_JAL:   RegDst = 2'b00;
                default: ;
            endcase
        end

        case (state)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if (is_jump) begin
                    PCWre = 1'b1;
                    PCSrc = (opcode == OP_JR) ? 2'b10 : 2'b11;
                    if (opcode == OP_JAL) begin
                        RegWre    = 1'b1;
                        WrRegDSrc = 1'b0;
                    end
                end else if (!is_halt && !is_branch && !is_mem && !is_alu) begin
                    PCWre = 1'b1;
                end
            end
            S_WB: begin
                PCWre     = 1'b1;
                RegWre    = ~ovf_q;
                DBDataSrc = 1'b0;
                WrRegDSrc = 1'b1;
            end
            S_BR: begin
                PCWre = 1'b1;
                PCSrc = br_taken ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                end else if (opcode == OP_LW) begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                end
            end
            S_WBL: begin
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus random instruction stream.
// Reference model derives the state sequence and strobes from instruction class and cycle position.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       overflow = 1'b0;
    logic [2:0] state;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0] RegDst;
    logic       RegWre, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic       ifNeedOf;
    logic [4:0] link_reg;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign), .overflow(overflow),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .ifNeedOf(ifNeedOf), .link_reg(link_reg)
    );

    always #5 CLK = ~CLK;

    // Instruction classes: 0 undefined, 1 jump, 2 branch, 3 alu, 4 sw, 5 lw, 6 halt
    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b010100, 6'b100101,
            6'b011000, 6'b000010, 6'b010000, 6'b010010, 6'b100110: return 3;
            6'b110100, 6'b110101, 6'b110110: return 2;
            6'b110000: return 4;
            6'b110001: return 5;
            6'b111000, 6'b111001, 6'b111010: return 1;
            6'b111111: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] ref_aluop(input logic [5:0] op);
        case (op)
            6'b000001, 6'b110100, 6'b110101, 6'b110110: return 3'b001;
            6'b010001, 6'b010000: return 3'b100;
            6'b010011, 6'b010010: return 3'b011;
            6'b010100: return 3'b111;
            6'b100101, 6'b100110: return 3'b110;
            6'b011000: return 3'b010;
            6'b000010, 6'b110000, 6'b110001: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Register-register forms (including sll) target rd, immediates target rt
    function automatic logic is_rform(input logic [5:0] op);
        return op inside {6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b010100, 6'b100101, 6'b011000};
    endfunction

    // Runs one instruction from IF back to IF and checks every cycle against the class model
    task automatic exec_instr(input logic [5:0] op, input logic z, input logic s, input logic ov);
        int         c;
        int         len;
        logic [2:0] seq [5];
        logic       need;
        logic       taken;
        logic [1:0] fin_pc;
        logic [1:0] e_pcsrc;
        logic       e_regwre;
        c = cls(op);
        need = (op == 6'b000000) || (op == 6'b000001);
        taken = (op == 6'b110100) ? z : (op == 6'b110101) ? !z : s;
        seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b000; seq[3] = 3'b000; seq[4] = 3'b000;
        case (c)
            2: begin len = 3; seq[2] = 3'b101; end
            3: begin len = 4; seq[2] = 3'b110; seq[3] = 3'b111; end
            4: begin len = 4; seq[2] = 3'b010; seq[3] = 3'b011; end
            5: begin len = 5; seq[2] = 3'b010; seq[3] = 3'b011; seq[4] = 3'b100; end
            default: len = 2;
        endcase
        fin_pc = 2'b00;
        if (op == 6'b111000 || op == 6'b111010) fin_pc = 2'b11;
        else if (op == 6'b111001)               fin_pc = 2'b10;
        else if (c == 2 && taken)               fin_pc = 2'b01;
        opcode = op; zero = z; sign = s; overflow = ov;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            e_pcsrc  = (i == len - 1) ? fin_pc : 2'b00;
            e_regwre = (c == 3 && i == 3) ? !(ov && need) :
                       ((c == 5 && i == 4) || (op == 6'b111010 && i == 1));
            n_cmp++; if (state !== seq[i]) begin n_err++;
                $display("FAIL state op=%b cyc=%0d got=%b exp=%b", op, i, state, seq[i]); end
            n_cmp++; if (PCWre !== (i == len - 1)) begin n_err++;
                $display("FAIL PCWre op=%b cyc=%0d got=%b exp=%b", op, i, PCWre, (i == len - 1)); end
            n_cmp++; if (IRWre !== (i == 0)) begin n_err++;
                $display("FAIL IRWre op=%b cyc=%0d got=%b exp=%b", op, i, IRWre, (i == 0)); end
            n_cmp++; if (RegWre !== e_regwre) begin n_err++;
                $display("FAIL RegWre op=%b cyc=%0d got=%b exp=%b", op, i, RegWre, e_regwre); end
            n_cmp++; if (mRD !== (c == 5 && i == 3) || mWR !== (c == 4 && i == 3)) begin n_err++;
                $display("FAIL mem_strobe op=%b cyc=%0d got=%b%b", op, i, mRD, mWR); end
            n_cmp++; if (PCSrc !== e_pcsrc) begin n_err++;
                $display("FAIL PCSrc op=%b cyc=%0d got=%b exp=%b", op, i, PCSrc, e_pcsrc); end
            if (c >= 2 && c <= 5 && i >= 1) begin
                n_cmp++; if (ALUOp !== ref_aluop(op) || ifNeedOf !== need) begin n_err++;
                    $display("FAIL alu_ctl op=%b cyc=%0d got=%b/%b exp=%b/%b", op, i, ALUOp, ifNeedOf, ref_aluop(op), need); end
            end
            if (c == 3 && i == 3) begin
                n_cmp++; if (RegDst !== (is_rform(op) ? 2'b10 : 2'b01) || ALUSrcB !== !is_rform(op)
                             || ALUSrcA !== (op == 6'b011000) || WrRegDSrc !== 1'b1 || DBDataSrc !== 1'b0) begin n_err++;
                    $display("FAIL wb_route op=%b got RegDst=%b A=%b B=%b W=%b D=%b", op, RegDst, ALUSrcA, ALUSrcB, WrRegDSrc, DBDataSrc); end
            end
            if (c == 5 && i >= 3) begin
                n_cmp++; if (DBDataSrc !== 1'b1 || (i == 4 && (RegDst !== 2'b01 || WrRegDSrc !== 1'b1))) begin n_err++;
                    $display("FAIL lw_route cyc=%0d got D=%b RegDst=%b W=%b", i, DBDataSrc, RegDst, WrRegDSrc); end
            end
            if (op == 6'b111010 && i == 1) begin
                n_cmp++; if (RegDst !== 2'b00 || WrRegDSrc !== 1'b0 || link_reg !== 5'd31) begin n_err++;
                    $display("FAIL jal_route got RegDst=%b W=%b link=%0d exp 00/0/31", RegDst, WrRegDSrc, link_reg); end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset;
        opcode = 6'b000001;
        #2;
        n_cmp++; if (state !== 3'b000 || IRWre !== 1'b1 || PCWre !== 1'b0 || RegWre !== 1'b0
                     || mRD !== 1'b0 || mWR !== 1'b0 || PCSrc !== 2'b00) begin n_err++;
            $display("FAIL reset_strobes st=%b IR=%b PC=%b RW=%b rd=%b wr=%b src=%b", state, IRWre, PCWre, RegWre, mRD, mWR, PCSrc); end
        n_cmp++; if (ALUOp !== 3'b000 || ifNeedOf !== 1'b0 || RegDst !== 2'b01 || ALUSrcA !== 1'b0
                     || ALUSrcB !== 1'b0 || ExtSel !== 1'b0 || DBDataSrc !== 1'b0 || WrRegDSrc !== 1'b0) begin n_err++;
            $display("FAIL reset_selects op=%b nof=%b dst=%b sel=%b%b%b%b%b", ALUOp, ifNeedOf, RegDst, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_alu;
        exec_instr(6'b000000, 1'b0, 1'b0, 1'b1);
        exec_instr(6'b000000, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b000001, 1'b0, 1'b0, 1'b1);
        exec_instr(6'b000010, 1'b0, 1'b0, 1'b1);
        exec_instr(6'b011000, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b100110, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch;
        exec_instr(6'b110100, 1'b1, 1'b0, 1'b0);
        exec_instr(6'b110100, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b110101, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b110110, 1'b0, 1'b1, 1'b0);
        exec_instr(6'b110110, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem;
        exec_instr(6'b110001, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b110000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_jump;
        exec_instr(6'b111010, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b111000, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b111001, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b101010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt;
        opcode = 6'b111111;
        @(posedge CLK); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_cmp++; if (state !== 3'b001 || PCWre !== 1'b0 || RegWre !== 1'b0) begin n_err++;
                $display("FAIL halt_hold cyc=%0d st=%b PCWre=%b RegWre=%b exp 001/0/0", i, state, PCWre, RegWre); end
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        #1;
        n_cmp++; if (state !== 3'b000) begin n_err++;
            $display("FAIL halt_exit st=%b exp=000", state); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset_mid_mem;
        opcode = 6'b110001;
        repeat (3) begin @(posedge CLK); #1; end
        n_cmp++; if (state !== 3'b011 || mRD !== 1'b1) begin n_err++;
            $display("FAIL pre_reset_mem st=%b mRD=%b exp 011/1", state, mRD); end
        RST = 1'b1;
        #1;
        n_cmp++; if (state !== 3'b000 || mRD !== 1'b0 || IRWre !== 1'b1 || mWR !== 1'b0
                     || RegWre !== 1'b0 || PCWre !== 1'b0) begin n_err++;
            $display("FAIL reset_mid_mem st=%b mRD=%b IR=%b mWR=%b RW=%b PC=%b", state, mRD, IRWre, mWR, RegWre, PCWre); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_random;
        logic [5:0] op;
        for (int k = 0; k < 150; k++) begin
            op = 6'($urandom_range(0, 63));
            if (op == 6'b111111) op = 6'b111010;
            exec_instr(op, 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back;
        exec_instr(6'b110001, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b000000, 1'b0, 1'b0, 1'b1);
        exec_instr(6'b110000, 1'b0, 1'b0, 1'b0);
        exec_instr(6'b000000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_jump();
        test_back_to_back();
        test_reset_mid_mem();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
